cpu_mem_dbus: RTL

Memory-stage data-bus master that consumes the EX-stage memory access request (ce/we/addr/sel/wdata) and executes it on a single-outstanding req/ack data bus. It stalls the pipeline while the transaction is in flight and extracts load results (byte/half sign or zero extension, LWL/LWR merge). It drains abandoned transactions after a flush and reports bus timeouts. It sits between the EX/MEM pipeline register and the data cache/bus bridge.

---
 rtl/cpu_mem_dbus.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_dbus.sv
// MEM-stage data-bus master: single-outstanding req/ack access, load extraction, flush drain, timeout.
// Optional build macro CPU_MEM_LWLR_EN enables the LWL/LWR merge with the old rt value.
package cpu_mem_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LL   = 4'd6,
    OP_LWC1 = 4'd7,
    OP_LWL  = 4'd8,
    OP_LWR  = 4'd9,
    OP_SB   = 4'd10,
    OP_SH   = 4'd11,
    OP_SW   = 4'd12,
    OP_SC   = 4'd13,
    OP_SWC1 = 4'd14
  } Oper_t;

  function automatic logic is_load(Oper_t o);
    return o inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWC1, OP_LWL, OP_LWR};
  endfunction
endpackage

module cpu_mem_dbus
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  Oper_t       op,
  input  logic        req_ce,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdata,
  input  logic        except_any,
  input  logic [31:0] reg2,
  output logic        stall_req,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [15:0] cnt;
  Oper_t       op_q;
  logic [1:0]  a_q;
  logic        start;
  logic        tmo;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;

`ifdef CPU_MEM_LWLR_EN
  logic [31:0] reg2_q;
`else
  logic        unused_reg2;
  assign unused_reg2 = ^reg2;
`endif

  assign start = req_ce & ~except_any & ~flush;
  assign tmo   = ~dbus_ack & (cnt == 16'(TIMEOUT - 1));

  // Gated by rst so the pipeline sees the reset value while reset is held.
  assign stall_req = ~rst & (((state == S_IDLE) & start) |
                             ((state == S_BUSY) & ~flush) |
                             ((state == S_DRAIN) & req_ce));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ext_data = dbus_rdata;
    byte_v   = dbus_rdata[{a_q, 3'b000} +: 8];
    half_v   = a_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (op_q)
      OP_LB:  ext_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU: ext_data = {24'd0, byte_v};
      OP_LH:  ext_data = {{16{half_v[15]}}, half_v};
      OP_LHU: ext_data = {16'd0, half_v};
`ifdef CPU_MEM_LWLR_EN
      OP_LWL: begin
        case (a_q)
          2'd0:    ext_data = {dbus_rdata[7:0],  reg2_q[23:0]};
          2'd1:    ext_data = {dbus_rdata[15:0], reg2_q[15:0]};
          2'd2:    ext_data = {dbus_rdata[23:0], reg2_q[7:0]};
          default: ext_data = dbus_rdata;
        endcase
      end
      OP_LWR: begin
        case (a_q)
          2'd1:    ext_data = {reg2_q[31:24], dbus_rdata[31:8]};
          2'd2:    ext_data = {reg2_q[31:16], dbus_rdata[31:16]};
          2'd3:    ext_data = {reg2_q[31:8],  dbus_rdata[31:24]};
          default: ext_data = dbus_rdata;
        endcase
      end
`endif
      default: ext_data = dbus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ld_valid   <= 1'b0;
      bus_err    <= 1'b0;
      ld_data    <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
      op_q       <= OP_NOP;
      a_q        <= '0;
`ifdef CPU_MEM_LWLR_EN
      reg2_q     <= '0;
`endif
    end else begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_BUSY;
            cnt        <= '0;
            dbus_req   <= 1'b1;
            dbus_we    <= req_we;
            dbus_addr  <= {req_addr[31:2], 2'b00};
            dbus_sel   <= req_sel;
            dbus_wdata <= req_wdata;
            op_q       <= op;
            a_q        <= req_addr[1:0];
`ifdef CPU_MEM_LWLR_EN
            reg2_q     <= reg2;
`endif
          end
        end
        S_BUSY: begin
          if (dbus_ack) begin
            // A flush in the ack cycle still retires the bus beat but discards the result.
            dbus_req <= 1'b0;
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DONE;
              ld_valid <= is_load(op_q);
              ld_data  <= is_load(op_q) ? ext_data : 32'd0;
            end
          end else if (flush) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else if (tmo) begin
            state    <= S_DONE;
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            ld_valid <= is_load(op_q);
            ld_data  <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_DRAIN: begin
          if (dbus_ack || tmo) begin
            state    <= S_IDLE;
            dbus_req <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
